mem_resp_stage: RTL and testbench
=================================

# mem_resp_stage

Parametrised memory-access pipeline stage that sits between EXE and WB. It holds one instruction, waits for the data-SRAM response (`data_ok`) on loads, and aligns and extends the returned data for 32- or 64-bit datapaths. It buffers a response that arrives while WB is stalled, and discards responses that belong to instructions flushed by a WB exception or `ertn`.

## Interface
Parameters
- `DATA_W`, 32: datapath width; 32 or 64.
- `MAX_OUTSTANDING`, 2: maximum data requests in flight; sizes the discard counter.
- `EX_W`, 4: width of the exception-code vector carried from EXE.

Ports
- `clk` in 1: clock.
- `resetn` in 1: active-low reset; one clock, asynchronous active-low reset.
- `es_to_ms_valid` in 1: EXE has an instruction.
- `ms_allowin` out 1: MEM can accept an instruction.
- `es_pc` in 32: PC.
- `es_alu_result` in DATA_W: ALU result or memory address.
- `es_ld_op` in 7: one-hot {b,bu,h,hu,w,wu,d}.
- `es_res_from_mem` in 1: instruction is a load.
- `es_mem_req` in 1: EXE issued a data request that was accepted.
- `es_gr_we` in 1: register write enable.
- `es_dest` in 5: destination register.
- `es_ex` in EX_W: exception flags from earlier stages.
- `data_sram_data_ok` in 1: response valid. Responses return in request order.
- `data_sram_rdata` in DATA_W: response data.
- `ws_allowin` in 1: WB can accept.
- `ms_to_ws_valid` out 1: MEM result valid to WB.
- `ms_pc` out 32, `ms_gr_we` out 1, `ms_dest` out 5: pass-through fields.
- `ms_final_result` out DATA_W: aligned load data or ALU result.
- `ms_ex` out 1: exception present in MEM.
- `out_ms_valid` out 1: MEM holds an instruction; used for ID forwarding and hazard checks.
- `ms_discard_busy` out 1: discard counter is non-zero. EXE must not issue a request while this is high.
- `wb_ex` in 1, `wb_ertn` in 1: flush.

## Operation
- FSM states:
  - `IDLE`: empty.
  - `RUN`: result ready; covers non-loads and excepted instructions.
  - `WAIT`: load waiting for `data_ok`.
  - `HOLD`: response captured, WB stalled.
- On accept (`es_to_ms_valid && ms_allowin`), the stage latches the fields. The next state is `WAIT` if `es_mem_req` is set, otherwise `RUN`.
- In `WAIT`, a `data_ok` with discard count 0 belongs to this instruction:
  - If `ws_allowin`, the result passes straight through.
  - Otherwise the stage captures rdata into the hold register and moves to `HOLD`.
- `ms_ready_go` is high in `RUN` and `HOLD`, and in `WAIT` only when a `data_ok` is claimed that cycle. `ms_allowin = !valid || (ms_ready_go && ws_allowin)`.
- Load alignment uses offset `alu_result[log2(DATA_W/8)-1:0]`:
  - b/bu select a byte; h/hu select a halfword (offset bit 0 ignored); w/wu select a word (offset low 2 bits ignored).
  - Signed ops sign-extend to DATA_W; unsigned ops zero-extend.
  - `d` returns full rdata.
  - With DATA_W=32, `wu` and `d` behave as `w`.
  - Non-loads return `alu_result`.
- Discard counter, width `$clog2(MAX_OUTSTANDING+1)`:
  - On flush, it increments by 1 if MEM is in `WAIT` and no `data_ok` is claimed this cycle.
  - Any `data_ok` while the counter is non-zero decrements it and is dropped. The decrement takes priority over claiming.
  - Simultaneous increment and decrement nets zero.
  - Counter overflow is a checked assertion.
- Flush (`wb_ex || wb_ertn`): next state `IDLE`, and nothing is latched that cycle. This applies in every state and overrides accept.
- `ms_ex = valid && (|es_ex)`, OR-ed with ALE when configured. Excepted instructions never enter `WAIT`.

## Timing
- Reset (async assert, sync release): state `IDLE`, hold register 0, discard count 0.
  - `ms_to_ws_valid`=0, `ms_allowin`=1, `ms_ex`=0, `out_ms_valid`=0, `ms_discard_busy`=0.
- Non-load: `ms_to_ws_valid` rises the cycle after accept.
- Load: `ms_to_ws_valid` rises combinationally in the `data_ok` cycle (0-cycle path from rdata), or in `HOLD` from the register. Minimum latency is 1 cycle after accept.
- Back-to-back: a new accept is possible in the same cycle the old result leaves.

## Configuration
- `MEM_ALE_CHECK_EN` defined:
  - Misaligned h/hu/w/wu/d addresses set `ms_ex` and an ALE flag in the `es_ex`-extended code.
  - The instruction enters `RUN`, never `WAIT`. EXE must not issue a request for it.
- `MEM_ALE_CHECK_EN` undefined: no check. Misaligned loads are handled by ignoring the low offset bits, as described above.

## Structure
- `mem_stage_pkg`: `ld_op` bit indices, `ms_state_e` {IDLE,RUN,WAIT,HOLD}, the ALE exception bit index, and the `DATA_W` legality check.
- Sub-module `mem_load_align`: combinational extract and extend, parametrised by DATA_W.

## Test plan
- Non-load, `alu_result`=0x0000_1234, `ws_allowin`=1 -> `ms_to_ws_valid` 1 cycle after accept, result 0x0000_1234.
- `ld.b`, address 0x...3, `data_ok` 2 cycles after accept, rdata 0x80FF_0000 -> result 0xFFFF_FF80 valid in the `data_ok` cycle.
- `ld.hu`, address 0x...2, rdata 0x80FF_1234, `ws_allowin`=0 at `data_ok` -> `HOLD`, `ms_allowin`=0. `ws_allowin`=1 two cycles later -> result 0x0000_80FF.
- Load in `WAIT`, `wb_ex` pulse -> `out_ms_valid`=0, `ms_discard_busy`=1. The next `data_ok` (0xDEAD_BEEF) is dropped and busy falls. A following `ld.w` gets its own rdata 0x1111_2222.
- Flush in the same cycle as `data_ok` -> counter stays 0, response consumed.
- DATA_W=64, `ld.wu`, offset 4, rdata 0xFFFF_FFFF_0000_0001 -> 0x0000_0000_FFFF_FFFF. With `MEM_ALE_CHECK_EN`, `ld.w` at 0x...2 -> `ms_ex`=1, no wait.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM response stage: load-op bit positions,
// FSM state encoding, ALE code position and datapath width legality.
package mem_stage_pkg;

    localparam int LD_OP_W = 7;
    // One-hot load op vector is {b, bu, h, hu, w, wu, d}
    localparam int LD_B  = 6;
    localparam int LD_BU = 5;
    localparam int LD_H  = 4;
    localparam int LD_HU = 3;
    localparam int LD_W  = 2;
    localparam int LD_WU = 1;
    localparam int LD_D  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ms_state_e;

    // ALE sits just above the exception bits carried in from EXE.
    function automatic int ale_ex_bit(input int ex_w);
        return ex_w;
    endfunction

    function automatic bit data_w_legal(input int w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/mem_resp_stage_if.sv
// EXE-to-MEM instruction bus plus the in-order data-SRAM response channel.
// master drives instructions and responses; slave is the MEM stage.
interface mem_resp_stage_if #(
    parameter int DATA_W = 32,
    parameter int EX_W   = 4
);
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic [31:0]       es_pc;
    logic [DATA_W-1:0] es_alu_result;
    logic [6:0]        es_ld_op;
    logic              es_res_from_mem;
    logic              es_mem_req;
    logic              es_gr_we;
    logic [4:0]        es_dest;
    logic [EX_W-1:0]   es_ex;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;

    modport master (
        output es_to_ms_valid, es_pc, es_alu_result, es_ld_op, es_res_from_mem,
               es_mem_req, es_gr_we, es_dest, es_ex, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_alu_result, es_ld_op, es_res_from_mem,
               es_mem_req, es_gr_we, es_dest, es_ex, data_sram_data_ok, data_sram_rdata,
        output ms_allowin
    );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load-data extract and sign/zero extend for 32/64-bit datapaths.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [LD_OP_W-1:0]           ld_op,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    input  logic [DATA_W-1:0]            rdata,
    output logic [DATA_W-1:0]            result
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    logic [7:0] lanes [NB];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lanes[gi] = rdata[gi*8 +: 8];
        end
    endgenerate

    // Halfword/word selection simply ignores the low offset bits.
    logic [OFF_W-1:0] off_h, off_w;
    assign off_h = offset & ~OFF_W'(1);
    assign off_w = offset & ~OFF_W'(3);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;
    assign byte_v = lanes[offset];
    assign half_v = {lanes[off_h | OFF_W'(1)], lanes[off_h]};
    assign word_v = {lanes[off_w | OFF_W'(3)], lanes[off_w | OFF_W'(2)],
                     lanes[off_w | OFF_W'(1)], lanes[off_w]};

    // On a 32-bit datapath word_v is all of rdata, so wu and d collapse to w.
    always_comb begin
        result = '0;
        if (ld_op[LD_B])  result = DATA_W'($signed(byte_v));
        if (ld_op[LD_BU]) result = DATA_W'(byte_v);
        if (ld_op[LD_H])  result = DATA_W'($signed(half_v));
        if (ld_op[LD_HU]) result = DATA_W'(half_v);
        if (ld_op[LD_W])  result = DATA_W'($signed(word_v));
        if (ld_op[LD_WU]) result = DATA_W'(word_v);
        if (ld_op[LD_D])  result = rdata;
    end
endmodule

// File: rtl/mem_resp_stage.sv
// MEM pipeline stage: holds one instruction, claims/buffers/discards in-order
// data-SRAM responses. Define MEM_ALE_CHECK_EN to flag misaligned loads as ALE.
module mem_resp_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int EX_W            = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mem_resp_stage_if.slave   es_bus,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_pc,
    output logic              ms_gr_we,
    output logic [4:0]        ms_dest,
    output logic [DATA_W-1:0] ms_final_result,
    output logic              ms_ex,
    output logic              out_ms_valid,
    output logic              ms_discard_busy,
    input  logic              wb_ex,
    input  logic              wb_ertn
);
    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
`ifdef MEM_ALE_CHECK_EN
    localparam int CODE_W = EX_W + 1;
`else
    localparam int CODE_W = EX_W;
`endif

    generate
        if (!data_w_legal(DATA_W)) begin : g_bad_data_w
            $fatal(1, "mem_resp_stage: DATA_W must be 32 or 64");
        end
    endgenerate

    ms_state_e          state_reg;
    logic [31:0]        pc_reg;
    logic [DATA_W-1:0]  alu_reg, hold_reg;
    logic [LD_OP_W-1:0] ld_op_reg;
    logic               res_from_mem_reg, gr_we_reg;
    logic [4:0]         dest_reg;
    logic [CODE_W-1:0]  ex_code_reg;
    logic [CNT_W-1:0]   discard_cnt_reg;

    logic flush, valid, claim, ready_go, accept, wait_entry, cnt_inc, cnt_dec;
    logic [CODE_W-1:0] ex_code_in;
    logic [DATA_W-1:0] load_src, load_data;

    assign flush    = wb_ex | wb_ertn;
    assign valid    = (state_reg != IDLE);
    // Responses seen while the discard count is non-zero belong to flushed loads.
    assign claim    = (state_reg == WAIT) && es_bus.data_sram_data_ok && (discard_cnt_reg == '0);
    assign ready_go = (state_reg == RUN) || (state_reg == HOLD) || claim;
    assign es_bus.ms_allowin = !valid || (ready_go && ws_allowin);
    assign accept   = es_bus.es_to_ms_valid && es_bus.ms_allowin && !flush;

`ifdef MEM_ALE_CHECK_EN
    logic             ale;
    logic [OFF_W-1:0] es_off;
    assign es_off = es_bus.es_alu_result[OFF_W-1:0];
    always_comb begin
        ale = 1'b0;
        if (es_bus.es_res_from_mem) begin
            if (es_bus.es_ld_op[LD_H] | es_bus.es_ld_op[LD_HU]) ale = es_off[0];
            if (es_bus.es_ld_op[LD_W] | es_bus.es_ld_op[LD_WU]) ale = |es_off[1:0];
            if (es_bus.es_ld_op[LD_D])                          ale = |es_off;
        end
    end
    assign ex_code_in = {ale, es_bus.es_ex};
`else
    assign ex_code_in = es_bus.es_ex;
`endif

    assign wait_entry = es_bus.es_mem_req && !(|ex_code_in);
    assign cnt_inc    = flush && (state_reg == WAIT) && !claim;
    assign cnt_dec    = es_bus.data_sram_data_ok && (discard_cnt_reg != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= IDLE;
            pc_reg           <= '0;
            alu_reg          <= '0;
            hold_reg         <= '0;
            ld_op_reg        <= '0;
            res_from_mem_reg <= 1'b0;
            gr_we_reg        <= 1'b0;
            dest_reg         <= '0;
            ex_code_reg      <= '0;
            discard_cnt_reg  <= '0;
        end else begin
            discard_cnt_reg <= discard_cnt_reg + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
            if (flush) begin
                state_reg <= IDLE;
            end else if (accept) begin
                state_reg        <= wait_entry ? WAIT : RUN;
                pc_reg           <= es_bus.es_pc;
                alu_reg          <= es_bus.es_alu_result;
                ld_op_reg        <= es_bus.es_ld_op;
                res_from_mem_reg <= es_bus.es_res_from_mem;
                gr_we_reg        <= es_bus.es_gr_we;
                dest_reg         <= es_bus.es_dest;
                ex_code_reg      <= ex_code_in;
            end else if (claim && !ws_allowin) begin
                state_reg <= HOLD;
                hold_reg  <= es_bus.data_sram_rdata;
            end else if (ready_go && ws_allowin) begin
                state_reg <= IDLE;
            end
        end
    end

    always @(posedge clk) begin
        if (resetn && cnt_inc && !cnt_dec)
            assert (32'(discard_cnt_reg) < MAX_OUTSTANDING);
    end

    assign load_src = (state_reg == HOLD) ? hold_reg : es_bus.data_sram_rdata;

    mem_load_align #(.DATA_W(DATA_W)) u_align (
        .ld_op  (ld_op_reg),
        .offset (alu_reg[OFF_W-1:0]),
        .rdata  (load_src),
        .result (load_data)
    );

    // Excepted loads sit in RUN with no response; they report the address instead.
    assign ms_final_result = (res_from_mem_reg && (state_reg != RUN)) ? load_data : alu_reg;
    assign ms_to_ws_valid  = valid && ready_go;
    assign ms_ex           = valid && (|ex_code_reg);
    assign out_ms_valid    = valid;
    assign ms_discard_busy = (discard_cnt_reg != '0);
    assign ms_pc           = pc_reg;
    assign ms_gr_we        = gr_we_reg;
    assign ms_dest         = dest_reg;
endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed + randomized bench for mem_resp_stage (32- and 64-bit instances).
module tb_mem_resp_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic ws_allowin, wb_ex, wb_ertn;
    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    mem_resp_stage_if #(.DATA_W(32), .EX_W(4)) bus32 ();
    mem_resp_stage_if #(.DATA_W(64), .EX_W(4)) bus64 ();

    logic        v32, gw32, ex32, ov32, busy32;
    logic [31:0] pc32, res32;
    logic [4:0]  dst32;
    logic        v64, gw64, ex64, ov64, busy64;
    logic [31:0] pc64;
    logic [63:0] res64;
    logic [4:0]  dst64;

    mem_resp_stage #(.DATA_W(32), .MAX_OUTSTANDING(2), .EX_W(4)) dut (
        .clk(clk), .resetn(resetn), .es_bus(bus32), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(v32), .ms_pc(pc32), .ms_gr_we(gw32), .ms_dest(dst32),
        .ms_final_result(res32), .ms_ex(ex32), .out_ms_valid(ov32),
        .ms_discard_busy(busy32), .wb_ex(wb_ex), .wb_ertn(wb_ertn)
    );

    mem_resp_stage #(.DATA_W(64), .MAX_OUTSTANDING(2), .EX_W(4)) dut64 (
        .clk(clk), .resetn(resetn), .es_bus(bus64), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(v64), .ms_pc(pc64), .ms_gr_we(gw64), .ms_dest(dst64),
        .ms_final_result(res64), .ms_ex(ex64), .out_ms_valid(ov64),
        .ms_discard_busy(busy64), .wb_ex(wb_ex), .wb_ertn(wb_ertn)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: load ops 0..6 = b,bu,h,hu,w,wu,d; natural-size slot that contains the offset.
    function automatic logic [63:0] ref_load(input int dw, input int op,
                                             input logic [63:0] addr, input logic [63:0] rd);
        int nb, off, size;
        bit sgn;
        logic [63:0] v, mask, dmask;
        nb  = dw / 8;
        off = int'(addr[5:0]) % nb;
        case (op)
            0: begin size = 1; sgn = 1'b1; end
            1: begin size = 1; sgn = 1'b0; end
            2: begin size = 2; sgn = 1'b1; end
            3: begin size = 2; sgn = 1'b0; end
            4: begin size = 4; sgn = 1'b1; end
            5: begin size = 4; sgn = 1'b0; end
            default: begin size = nb; sgn = 1'b0; end
        endcase
        mask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
        v = (rd >> (8 * ((off / size) * size))) & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
        dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return v & dmask;
    endfunction

    function automatic logic [6:0] onehot(input int op);
        logic [6:0] top;
        top = 7'b100_0000;
        return (op < 7) ? (top >> op) : 7'b0;
    endfunction

    task automatic idle32();
        bus32.es_to_ms_valid = 1'b0;
        bus32.es_mem_req = 1'b0;
        bus32.data_sram_data_ok = 1'b0;
        bus32.data_sram_rdata = '0;
    endtask

    // op 7 = non-load
    task automatic drive32(input logic [31:0] pc, input logic [31:0] addr, input int op,
                           input logic [3:0] ex, input logic req);
        bus32.es_to_ms_valid = 1'b1;
        bus32.es_pc = pc;
        bus32.es_alu_result = addr;
        bus32.es_ld_op = onehot(op);
        bus32.es_res_from_mem = (op < 7);
        bus32.es_mem_req = req;
        bus32.es_gr_we = 1'b1;
        bus32.es_dest = 5'(op + 1);
        bus32.es_ex = ex;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp;
        ws_allowin = 1'b1; wb_ex = 1'b0; wb_ertn = 1'b0;
        idle32();
        drive32(32'h0, 32'h0, 7, 4'h0, 1'b0);
        bus32.es_to_ms_valid = 1'b0;
        bus64.es_to_ms_valid = 1'b0; bus64.es_mem_req = 1'b0; bus64.data_sram_data_ok = 1'b0;
        bus64.data_sram_rdata = '0; bus64.es_pc = '0; bus64.es_alu_result = '0; bus64.es_ld_op = '0;
        bus64.es_res_from_mem = 1'b0; bus64.es_gr_we = 1'b0; bus64.es_dest = '0; bus64.es_ex = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", v32, 0); check("rst_allowin", bus32.ms_allowin, 1);
        check("rst_ex", ex32, 0);   check("rst_ms_valid", ov32, 0);
        check("rst_busy", busy32, 0);
        resetn = 1'b1;

        // Non-load passes one cycle after accept
        @(negedge clk); drive32(32'h100, 32'h0000_1234, 7, 4'h0, 1'b0); #1;
        check("nl_allowin", bus32.ms_allowin, 1); check("nl_valid_acc", v32, 0);
        @(negedge clk); idle32(); #1;
        check("nl_valid", v32, 1); check("nl_result", res32, 32'h0000_1234);
        check("nl_pc", pc32, 32'h100); check("nl_dest", dst32, 5'd8);
        @(negedge clk); #1; check("nl_gone", ov32, 0);

        // Back-to-back non-loads
        @(negedge clk); drive32(32'h200, 32'hA, 7, 4'h0, 1'b0);
        @(negedge clk); drive32(32'h204, 32'hB, 7, 4'h0, 1'b0); #1;
        check("b2b_allowin", bus32.ms_allowin, 1); check("b2b_res_a", res32, 32'hA);
        @(negedge clk); idle32(); #1;
        check("b2b_valid_b", v32, 1); check("b2b_res_b", res32, 32'hB);

        // ld.b, response two cycles after accept
        @(negedge clk); drive32(32'h300, 32'h0000_1003, 0, 4'h0, 1'b1);
        @(negedge clk); idle32(); #1;
        check("ldb_wait_valid", v32, 0); check("ldb_wait_ms", ov32, 1);
        check("ldb_wait_allowin", bus32.ms_allowin, 0);
        @(negedge clk); bus32.data_sram_data_ok = 1'b1; bus32.data_sram_rdata = 32'h80FF_0000; #1;
        check("ldb_valid", v32, 1); check("ldb_result", res32, 32'hFFFF_FF80);
        @(negedge clk); idle32(); #1; check("ldb_gone", ov32, 0);

        // ld.hu with WB stalled -> HOLD
        @(negedge clk); drive32(32'h400, 32'h0000_2002, 3, 4'h0, 1'b1);
        @(negedge clk); idle32();
        @(negedge clk); bus32.data_sram_data_ok = 1'b1; bus32.data_sram_rdata = 32'h80FF_1234;
        ws_allowin = 1'b0; #1;
        check("hu_ok_valid", v32, 1); check("hu_ok_allowin", bus32.ms_allowin, 0);
        check("hu_ok_result", res32, 32'h0000_80FF);
        @(negedge clk); idle32(); bus32.data_sram_rdata = 32'h1357_9BDF; #1;
        check("hu_hold_valid", v32, 1); check("hu_hold_allowin", bus32.ms_allowin, 0);
        check("hu_hold_result", res32, 32'h0000_80FF);
        @(negedge clk); ws_allowin = 1'b1; #1;
        check("hu_rel_allowin", bus32.ms_allowin, 1); check("hu_rel_result", res32, 32'h0000_80FF);
        @(negedge clk); idle32(); #1; check("hu_gone", ov32, 0);

        // Flush while waiting: next response is discarded
        @(negedge clk); drive32(32'h500, 32'h0000_3000, 4, 4'h0, 1'b1);
        @(negedge clk); idle32(); wb_ex = 1'b1;
        @(negedge clk); wb_ex = 1'b0; #1;
        check("fl_ms_valid", ov32, 0); check("fl_busy", busy32, 1);
        @(negedge clk); bus32.data_sram_data_ok = 1'b1; bus32.data_sram_rdata = 32'hDEAD_BEEF; #1;
        check("fl_drop_valid", v32, 0);
        @(negedge clk); idle32(); #1; check("fl_busy_fall", busy32, 0);
        drive32(32'h504, 32'h0000_3004, 4, 4'h0, 1'b1);
        @(negedge clk); idle32();
        @(negedge clk); bus32.data_sram_data_ok = 1'b1; bus32.data_sram_rdata = 32'h1111_2222; #1;
        check("fl_next_valid", v32, 1); check("fl_next_result", res32, 32'h1111_2222);

        // Flush coinciding with data_ok: response consumed, nothing to discard
        @(negedge clk); idle32(); drive32(32'h600, 32'h0000_4000, 4, 4'h0, 1'b1);
        @(negedge clk); idle32(); bus32.data_sram_data_ok = 1'b1;
        bus32.data_sram_rdata = 32'h5555_AAAA; wb_ertn = 1'b1;
        @(negedge clk); idle32(); wb_ertn = 1'b0; #1;
        check("flok_busy", busy32, 0); check("flok_ms_valid", ov32, 0);
        drive32(32'h604, 32'h0000_4004, 4, 4'h0, 1'b1);
        @(negedge clk); idle32();
        @(negedge clk); bus32.data_sram_data_ok = 1'b1; bus32.data_sram_rdata = 32'h600D_600D; #1;
        check("flok_next_result", res32, 32'h600D_600D);

        // Flush overrides accept
        @(negedge clk); idle32(); drive32(32'h700, 32'h77, 7, 4'h0, 1'b0); wb_ex = 1'b1;
        @(negedge clk); idle32(); wb_ex = 1'b0; #1;
        check("flacc_ms_valid", ov32, 0);

        // Exception from EXE: no wait, ms_ex set
        drive32(32'h800, 32'h0000_5000, 4, 4'b0100, 1'b0);
        @(negedge clk); idle32(); #1;
        check("exc_valid", v32, 1); check("exc_ms_ex", ex32, 1);
        @(negedge clk); #1; check("exc_gone_ex", ex32, 0);

`ifdef MEM_ALE_CHECK_EN
        drive32(32'h900, 32'h0000_6002, 4, 4'h0, 1'b0);
        @(negedge clk); idle32(); #1;
        check("ale_valid", v32, 1); check("ale_ms_ex", ex32, 1);
        @(negedge clk);
`endif

        // Randomized 32-bit transactions
        for (int t = 0; t < 40; t++) begin
            int op, d, s;
            logic [31:0] addr, rd;
            op = $urandom_range(0, 7);
            d = $urandom_range(0, 2);
            s = $urandom_range(0, 2);
            addr = $urandom;
            rd = $urandom;
            exp = (op == 7) ? {32'h0, addr} : ref_load(32, op, {32'h0, addr}, {32'h0, rd});
            drive32(32'h1000 + 32'(t * 4), addr, op, 4'h0, op < 7);
            #1; check("rnd_allowin", bus32.ms_allowin, 1);
            if (op == 7) begin
                @(negedge clk); idle32(); #1;
                check("rnd_nl_valid", v32, 1); check("rnd_nl_result", res32, exp);
            end else begin
                for (int i = 0; i < d; i++) begin
                    @(negedge clk); idle32(); #1; check("rnd_wait_valid", v32, 0);
                end
                @(negedge clk); idle32(); bus32.data_sram_data_ok = 1'b1;
                bus32.data_sram_rdata = rd; ws_allowin = (s == 0); #1;
                check("rnd_ld_valid", v32, 1); check("rnd_ld_result", res32, exp);
                for (int i = 0; i < s; i++) begin
                    @(negedge clk); idle32(); bus32.data_sram_rdata = $urandom;
                    ws_allowin = (i == s - 1); #1;
                    check("rnd_hold_valid", v32, 1); check("rnd_hold_result", res32, exp);
                end
            end
            $display("txn32 %0d op=%0d addr=%h rdata=%h delay=%0d stall=%0d result=%h",
                     t, op, addr, rd, d, s, res32);
            @(negedge clk); idle32(); ws_allowin = 1'b1;
        end

        // 64-bit datapath
        for (int t = 0; t < 16; t++) begin
            int op;
            logic [63:0] addr, rd;
            op   = (t == 0) ? 5 : $urandom_range(0, 6);
            addr = (t == 0) ? 64'h0000_0000_0000_1004 : {32'h0, 32'($urandom)};
            rd   = (t == 0) ? 64'hFFFF_FFFF_0000_0001 : {32'($urandom), 32'($urandom)};
            exp  = (t == 0) ? 64'h0000_0000_FFFF_FFFF : ref_load(64, op, addr, rd);
            bus64.es_to_ms_valid = 1'b1; bus64.es_pc = 32'h2000 + 32'(t * 4);
            bus64.es_alu_result = addr; bus64.es_ld_op = onehot(op);
            bus64.es_res_from_mem = 1'b1; bus64.es_mem_req = 1'b1; bus64.es_ex = '0;
            @(negedge clk);
            bus64.es_to_ms_valid = 1'b0; bus64.es_mem_req = 1'b0;
            bus64.data_sram_data_ok = 1'b1; bus64.data_sram_rdata = rd; #1;
            check("d64_valid", v64, 1); check("d64_result", res64, exp);
            $display("txn64 %0d op=%0d addr=%h rdata=%h result=%h", t, op, addr, rd, res64);
            @(negedge clk); bus64.data_sram_data_ok = 1'b0;
        end
        #1; check("d64_gone", ov64, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
